// File: rtl/sprite_line_renderer.sv
// ---------------------------------------------------------------------------
// sprite_line_renderer
//
// Per-scanline sprite stage.  On every line_start pulse it fetches one
// 16-pixel sprite row into the back bank of a ping-pong line buffer over a
// req/ack memory handshake.  It then displays the front bank at the
// horizontal positions covered by the sprite during the following line.
//
// Optional feature macro: SPRITE_MIRROR_EN
//   defined   -> adds spr_hflip input, latched per bank; display is mirrored
//   undefined -> no spr_hflip port, display always reads front[col]
//
// Ports:
//   pixel_clk   pixel clock
//   rst         asynchronous active-low reset
//   line_start  one-cycle pulse at start of horizontal blanking
//   v_next      visible line about to be drawn (valid with line_start)
//   h_pos       current visible x position
//   spr_x/y     sprite top-left corner (sampled at line_start)
//   spr_id      sprite index (sampled at line_start)
//   spr_hflip   horizontal mirror flag (SPRITE_MIRROR_EN only)
//   mem_req     memory request
//   mem_addr    {spr_id, row[3:0], col[3:0]}
//   mem_ack     memory acknowledge, mem_data valid in the same cycle
//   mem_data    pixel data from sprite memory
//   pix_out     sprite pixel colour (registered)
//   pix_valid   sprite pixel present and opaque (registered)
//   err_late    sticky flag: a fetch was aborted by line_start
// ---------------------------------------------------------------------------
module sprite_line_renderer #(
    parameter int                   COLOR_W      = 8,
    parameter logic [COLOR_W-1:0]   TRANSP_COLOR = {COLOR_W{1'b0}}
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               line_start,
    input  logic [9:0]         v_next,
    input  logic [9:0]         h_pos,
    input  logic [9:0]         spr_x,
    input  logic [9:0]         spr_y,
    input  logic [3:0]         spr_id,
`ifdef SPRITE_MIRROR_EN
    input  logic               spr_hflip,
`endif
    output logic               mem_req,
    output logic [11:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [COLOR_W-1:0] mem_data,
    output logic [COLOR_W-1:0] pix_out,
    output logic               pix_valid,
    output logic               err_late
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         fcol_q, fcol_d;
    logic [3:0]         fid_q, fid_d;
    logic [3:0]         frow_q, frow_d;
    logic               req_q, req_d;
    logic [11:0]        addr_q, addr_d;
    logic               front_sel_q, front_sel_d;
    logic [1:0]         bank_vld_q, bank_vld_d;
    logic [1:0][9:0]    bank_x_q, bank_x_d;
    logic               err_q, err_d;
    logic [COLOR_W-1:0] pix_q, pix_d;
    logic               pvld_q, pvld_d;
`ifdef SPRITE_MIRROR_EN
    logic [1:0]         bank_flip_q, bank_flip_d;
`endif

    // Line buffers are data-only storage; contents after reset are don't-care.
    logic [COLOR_W-1:0] buf_q [0:1][0:15];

    logic               back_s;
    logic [9:0]         row_s;
    logic               in_range_s;
    logic               wr_en_s;
    logic [9:0]         front_x_s;
    logic [9:0]         dcol_s;
    logic               hit_s;
    logic               flip_s;
    logic [3:0]         idx_s;
    logic [COLOR_W-1:0] pixel_s;

    // Sprite row selection: unsigned difference, so lines above the sprite
    // are rejected by the explicit compare and lines below by row >= 16.
    always_comb begin
        back_s     = ~front_sel_q;
        row_s      = v_next - spr_y;
        in_range_s = (v_next >= spr_y) && (row_s < 10'd16);
    end

    // Fetch FSM next-state, bank bookkeeping and memory request generation.
    always_comb begin
        state_d     = state_q;
        fcol_d      = fcol_q;
        fid_d       = fid_q;
        frow_d      = frow_q;
        req_d       = req_q;
        addr_d      = addr_q;
        front_sel_d = front_sel_q;
        bank_vld_d  = bank_vld_q;
        bank_x_d    = bank_x_q;
        err_d       = err_q;
        wr_en_s     = 1'b0;
`ifdef SPRITE_MIRROR_EN
        bank_flip_d = bank_flip_q;
`endif
        if (line_start) begin
            // The old front becomes the new back bank; the old back keeps
            // its valid bit, which is only set if its fetch completed.
            front_sel_d             = ~front_sel_q;
            bank_vld_d[front_sel_q] = 1'b0;
            bank_x_d[front_sel_q]   = spr_x;
`ifdef SPRITE_MIRROR_EN
            bank_flip_d[front_sel_q] = spr_hflip;
`endif
            if (state_q == FETCH) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (in_range_s) begin
                fid_d   = spr_id;
                frow_d  = row_s[3:0];
                fcol_d  = 4'd0;
                req_d   = 1'b1;
                addr_d  = {spr_id, row_s[3:0], 4'd0};
                state_d = FETCH;
            end else begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    req_d = 1'b0;
                end
                FETCH: begin
                    if (mem_ack) begin
                        wr_en_s = 1'b1;
                        if (fcol_q == 4'd15) begin
                            bank_vld_d[back_s] = 1'b1;
                            req_d              = 1'b0;
                            state_d            = IDLE;
                        end else begin
                            fcol_d = fcol_q + 4'd1;
                            addr_d = {fid_q, frow_q, fcol_q + 4'd1};
                        end
                    end else begin
                        req_d = 1'b1;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Display lookup: column relative to the latched front-bank x position.
    always_comb begin
        front_x_s = bank_x_q[front_sel_q];
        dcol_s    = h_pos - front_x_s;
        hit_s     = (h_pos >= front_x_s) && (dcol_s < 10'd16) && bank_vld_q[front_sel_q];
`ifdef SPRITE_MIRROR_EN
        flip_s    = bank_flip_q[front_sel_q];
`else
        flip_s    = 1'b0;
`endif
        if (flip_s) begin
            idx_s = 4'd15 - dcol_s[3:0];
        end else begin
            idx_s = dcol_s[3:0];
        end
        pixel_s = buf_q[front_sel_q][idx_s];
        if (hit_s) begin
            pix_d  = pixel_s;
            pvld_d = (pixel_s != TRANSP_COLOR);
        end else begin
            pix_d  = {COLOR_W{1'b0}};
            pvld_d = 1'b0;
        end
    end

    // State, control and output registers with asynchronous reset.
    always_ff @(posedge pixel_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fcol_q      <= 4'd0;
            fid_q       <= 4'd0;
            frow_q      <= 4'd0;
            req_q       <= 1'b0;
            addr_q      <= 12'd0;
            front_sel_q <= 1'b0;
            bank_vld_q  <= 2'b00;
            bank_x_q    <= {2{10'd0}};
            err_q       <= 1'b0;
            pix_q       <= {COLOR_W{1'b0}};
            pvld_q      <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            bank_flip_q <= 2'b00;
`endif
        end else begin
            state_q     <= state_d;
            fcol_q      <= fcol_d;
            fid_q       <= fid_d;
            frow_q      <= frow_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            front_sel_q <= front_sel_d;
            bank_vld_q  <= bank_vld_d;
            bank_x_q    <= bank_x_d;
            err_q       <= err_d;
            pix_q       <= pix_d;
            pvld_q      <= pvld_d;
`ifdef SPRITE_MIRROR_EN
            bank_flip_q <= bank_flip_d;
`endif
        end
    end

    // Back-bank write port, one pixel per acknowledged request.
    always_ff @(posedge pixel_clk) begin
        if (wr_en_s) begin
            buf_q[back_s][fcol_q] <= mem_data;
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign pix_out   = pix_q;
    assign pix_valid = pvld_q;
    assign err_late  = err_q;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Testbench for sprite_line_renderer: directed table vectors, hand-written
// multi-cycle sequences and randomized lines checked against a line-level
// reference model.
module tb_sprite_line_renderer;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic        line_start;
    logic [9:0]  v_next, h_pos, spr_x, spr_y;
    logic [3:0]  spr_id;
    logic        spr_hflip;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        err_late;

    sprite_line_renderer #(.COLOR_W(8), .TRANSP_COLOR(8'd0)) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .line_start (line_start),
        .v_next     (v_next),
        .h_pos      (h_pos),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_id     (spr_id),
`ifdef SPRITE_MIRROR_EN
        .spr_hflip  (spr_hflip),
`endif
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .err_late   (err_late)
    );

    always #5 pixel_clk = ~pixel_clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    // Reference model: one sprite row per bank, tracked at line granularity.
    logic [7:0] m_back [16];
    logic [7:0] m_front [16];
    bit  m_back_vis, m_back_done, m_front_valid, m_err;
    bit  m_back_flip, m_front_flip;
    int  m_back_x, m_front_x, m_id, m_row, m_acks;

    typedef struct {
        int         h;
        logic [7:0] pix;
        logic       vld;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    function automatic logic [7:0] memf(input logic [11:0] a);
        logic [15:0] t;
        t = {4'd0, a} * 16'd37 + 16'd11;
        case (mode)
            0:       memf = {4'd0, a[3:0]} + 8'd1;
            1:       memf = (a[3:0] == 4'd5) ? 8'd0 : {4'd0, a[3:0]} + 8'd1;
            default: memf = t[7:0] ^ {a[11:8], a[3:0]};
        endcase
    endfunction

    task automatic model_reset();
        m_back_vis = 0; m_back_done = 0; m_front_valid = 0; m_err = 0;
        m_back_flip = 0; m_front_flip = 0; m_acks = 0;
        m_back_x = 0; m_front_x = 0;
    endtask

    // Expected registered display output for horizontal position h.
    task automatic expect_px(input int h, output int pix, output int vld);
        int c;
        pix = 0; vld = 0;
        if (m_front_valid && h >= m_front_x && (h - m_front_x) < 16) begin
            c   = h - m_front_x;
            pix = m_front_flip ? m_front[15 - c] : m_front[c];
            vld = (pix != 0) ? 1 : 0;
        end
    endtask

    // Line start: update the model, pulse the DUT, check request and error.
    task automatic ls(input int v, input int x, input int y, input int id, input int flip);
        bit vis;
        if (m_back_vis && !m_back_done) m_err = 1;
        for (int c = 0; c < 16; c++) m_front[c] = m_back[c];
        m_front_valid = m_back_vis && m_back_done;
        m_front_x     = m_back_x;
        m_front_flip  = m_back_flip;
        vis = (v >= y) && ((v - y) < 16);
        m_back_vis = vis; m_back_done = 0; m_back_x = x; m_acks = 0;
`ifdef SPRITE_MIRROR_EN
        m_back_flip = (flip != 0);
`else
        m_back_flip = 0;
`endif
        m_id = id; m_row = v - y;
        if (vis) begin
            for (int c = 0; c < 16; c++)
                m_back[c] = memf(12'((id % 16) * 256 + (m_row % 16) * 16 + c));
        end
        line_start = 1'b1; v_next = 10'(v); spr_x = 10'(x); spr_y = 10'(y);
        spr_id = 4'(id); spr_hflip = (flip != 0); mem_ack = 1'b0;
        step();
        line_start = 1'b0;
        chk("req_after_line_start", int'(mem_req), int'(vis));
        chk("err_late", int'(err_late), int'(m_err));
    endtask

    // One memory cycle driven by the bench; address checked on every ack.
    task automatic mem_cycle(input bit a);
        mem_ack  = a;
        mem_data = memf(mem_addr);
        if (a && m_back_vis && !m_back_done && m_acks < 16) begin
            chk("req_on_ack", int'(mem_req), 1);
            chk("mem_addr", int'(mem_addr), m_id * 256 + m_row * 16 + m_acks);
            m_acks++;
            if (m_acks == 16) m_back_done = 1;
        end
        step();
    endtask

    // Partial fetch: ack every 'every' cycles for ncyc cycles.
    task automatic fetch_partial(input int ncyc, input int every);
        for (int c = 0; c < ncyc; c++) mem_cycle((c % every) == 0);
        mem_ack = 1'b0;
    endtask

    // Complete the pending fetch; ackmode 1 = held high, 0 = random.
    task automatic fetch_run(input int ackmode);
        int cyc = 0;
        while (!m_back_done && cyc < 200) begin
            mem_cycle(ackmode == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
            cyc++;
        end
        mem_ack = 1'b0;
        chk("fetch_bound", int'(m_back_done), 1);
        chk("req_low_after_fetch", int'(mem_req), 0);
    endtask

    // Idle cycles with stray acks that must be ignored.
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            mem_ack = 1'b1; mem_data = 8'hA5;
            step();
            chk("req_idle", int'(mem_req), 0);
        end
        mem_ack = 1'b0;
    endtask

    task automatic sweep(input int lo, input int hi);
        int ep, ev;
        for (int h = lo; h <= hi; h++) begin
            h_pos = 10'(h);
            step();
            expect_px(h, ep, ev);
            chk("pix_out", int'(pix_out), ep);
            chk("pix_valid", int'(pix_valid), ev);
        end
    endtask

    task automatic px(input int h, input int ep, input int ev);
        h_pos = 10'(h);
        step();
        chk("pix_out_dir", int'(pix_out), ep);
        chk("pix_valid_dir", int'(pix_valid), ev);
    endtask

    initial begin
        rst = 1'b0; line_start = 1'b0; v_next = '0; h_pos = '0; spr_x = '0;
        spr_y = '0; spr_id = '0; spr_hflip = 1'b0; mem_ack = 1'b0; mem_data = '0;
        model_reset();
        step(); step();
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_err_late", int'(err_late), 0);
        rst = 1'b1;
        step();

        // Ramp fetch: 16 acks back to back, req falls 17 cycles after line_start.
        tbl[0] = '{99, 8'd0, 1'b0};   tbl[1] = '{100, 8'd1, 1'b1};
        tbl[2] = '{101, 8'd2, 1'b1};  tbl[3] = '{108, 8'd9, 1'b1};
        tbl[4] = '{115, 8'd16, 1'b1}; tbl[5] = '{116, 8'd0, 1'b0};
        tbl[6] = '{0, 8'd0, 1'b0};    tbl[7] = '{639, 8'd0, 1'b0};
        mode = 0;
        ls(52, 100, 50, 0, 0);
        fetch_run(1);
        ls(200, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            h_pos = 10'(tbl[i].h);
            step();
            chk("tbl_pix_out", int'(pix_out), int'(tbl[i].pix));
            chk("tbl_pix_valid", int'(pix_valid), int'(tbl[i].vld));
        end
        sweep(0, 639);

        // Transparent colour at column 5.
        mode = 1;
        ls(52, 100, 50, 0, 0);
        fetch_run(1);
        ls(200, 0, 0, 0, 0);
        px(104, 5, 1); px(105, 0, 0); px(106, 7, 1);

        // Lines just outside the sprite: no request, no output.
        mode = 2;
        ls(49, 100, 50, 2, 0); idle(20);
        ls(66, 100, 50, 2, 0); idle(5); sweep(0, 639);
        ls(200, 0, 0, 0, 0);   sweep(0, 639);

        // Late fetch: ack every third cycle, next line_start after 20 cycles.
        chk("err_before_late", int'(err_late), 0);
        ls(52, 100, 50, 3, 0);
        fetch_partial(20, 3);
        ls(300, 200, 290, 5, 0);
        sweep(0, 639);
        fetch_run(0);
        ls(200, 0, 0, 0, 0);
        sweep(190, 220);
        chk("err_sticky", int'(err_late), 1);

        // Right-edge clipping and left edge.
        ls(52, 630, 50, 7, 0); fetch_run(1);
        ls(200, 0, 0, 0, 0);   sweep(620, 639);
        ls(52, 0, 50, 9, 0);   fetch_run(0);
        ls(200, 0, 0, 0, 0);   sweep(0, 20);

        // Reset in the middle of a fetch.
        mode = 0;
        ls(52, 100, 50, 0, 0);
        fetch_partial(5, 1);
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", int'(mem_req), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        chk("midrst_pix_out", int'(pix_out), 0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_err_late", int'(err_late), 0);
        model_reset();
        #3 rst = 1'b1;
        step();
        ls(200, 0, 0, 0, 0); sweep(90, 130);
        ls(52, 100, 50, 0, 1); fetch_run(1);
        ls(200, 0, 0, 0, 0);
`ifdef SPRITE_MIRROR_EN
        px(100, 16, 1); px(115, 1, 1);
`else
        px(100, 1, 1);  px(115, 16, 1);
`endif
        sweep(95, 120);

        // Randomized lines against the model.
        mode = 2;
        for (int it = 0; it < 20; it++) begin
            int v, x, y, r;
            v = $urandom_range(0, 479);
            x = $urandom_range(0, 639);
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 2) != 0) y = (v >= r) ? v - r : v + 5;
            else y = $urandom_range(0, 639);
            ls(v, x, y, $urandom_range(0, 15), $urandom_range(0, 1));
            if (m_back_vis) fetch_run(0);
            else idle(5);
            sweep(0, 639);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
